// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and opcode classification helpers shared by the
// ALU arbiter and its response buffers.
//   is_flag_op(op) : 1 for opcodes that are allowed to update N/Z/V
//   is_ctrl_op(op) : 1 for the 11xx control group (B/BR/PCS/HLT)
package alu_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] OP_ADD    = 4'b0000;
  localparam logic [ALU_OPW-1:0] OP_SUB    = 4'b0001;
  localparam logic [ALU_OPW-1:0] OP_XOR    = 4'b0010;
  localparam logic [ALU_OPW-1:0] OP_RED    = 4'b0011;
  localparam logic [ALU_OPW-1:0] OP_SLL    = 4'b0100;
  localparam logic [ALU_OPW-1:0] OP_SRA    = 4'b0101;
  localparam logic [ALU_OPW-1:0] OP_ROR    = 4'b0110;
  localparam logic [ALU_OPW-1:0] OP_PADDSB = 4'b0111;
  localparam logic [ALU_OPW-1:0] OP_LW     = 4'b1000;
  localparam logic [ALU_OPW-1:0] OP_SW     = 4'b1001;
  localparam logic [ALU_OPW-1:0] OP_LHB    = 4'b1010;
  localparam logic [ALU_OPW-1:0] OP_LLB    = 4'b1011;
  localparam logic [ALU_OPW-1:0] OP_B      = 4'b1100;
  localparam logic [ALU_OPW-1:0] OP_BR     = 4'b1101;
  localparam logic [ALU_OPW-1:0] OP_PCS    = 4'b1110;
  localparam logic [ALU_OPW-1:0] OP_HLT    = 4'b1111;

  // Opcodes whose result may legitimately update the N/Z/V flags.
  function automatic logic is_flag_op(input logic [ALU_OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Control-flow group: accepted but the buffered result is forced to zero.
  function automatic logic is_ctrl_op(input logic [ALU_OPW-1:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_rsp_buf.sv
// alu_rsp_buf: one-entry valid/ready register slice.
//   load_i       : write load_data_i this cycle (caller only loads when the
//                  slot is empty or being drained)
//   load_data_i  : value to capture
//   out_ready_i  : consumer takes the entry this cycle
//   out_valid_o  : entry occupied
//   out_data_o   : entry contents, stable while out_valid_o & !out_ready_i
// A load in the same cycle as a drain keeps the slot full, so a consumer
// that is always ready sees one result per cycle with no bubble.
module alu_rsp_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between the pipeline EX
// stage (port 0) and the address-generation/aux unit (port 1).
//   reqN_valid/ready/op/a/b : request handshake per port
//   rspN_valid/ready/data   : registered one-entry response per port
//   alu_in1/alu_in2/opcode  : operands to the ALU from the granted port
//   alu_out                 : ALU result, captured at the end of the grant cycle
//   alu_flag_wen            : N/Z/V update permit, port 0 flag ops only
//   busy                    : any response held or any request pending
// Round-robin: when both ports are eligible the pointer port wins, and every
// grant hands priority to the other port.
module alu_arbiter #(
  parameter int DW      = 16,
  parameter int OPW     = 4,
  parameter int RR_INIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_data,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  output logic [OPW-1:0] alu_opcode,
  input  logic [DW-1:0]  alu_out,
  output logic           alu_flag_wen,
  output logic           busy
);
  import alu_pkg::*;

  logic [1:0]    req_valid, rsp_valid, rsp_ready, elig, grant;
  logic [DW-1:0] rsp_data [2];
  logic [DW-1:0] cap_data;
  logic          ptr_q, ptr_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // A full buffer that drains this cycle can accept the new result.
      assign elig[gi] = req_valid[gi] & (~rsp_valid[gi] | rsp_ready[gi]);

      alu_rsp_buf #(.DW(DW)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (grant[gi]),
        .load_data_i (cap_data),
        .out_ready_i (rsp_ready[gi]),
        .out_valid_o (rsp_valid[gi]),
        .out_data_o  (rsp_data[gi])
      );
    end
  endgenerate

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
      else               grant = elig;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= (RR_INIT != 0);
    else     ptr_q <= ptr_d;
  end

  // Idle cycles present RED with zero operands, which has no flag effect.
  always_comb begin
    alu_in1    = '0;
    alu_in2    = '0;
    alu_opcode = OPW'(OP_RED);
    if (grant[0]) begin
      alu_in1    = req0_a;
      alu_in2    = req0_b;
      alu_opcode = req0_op;
    end else if (grant[1]) begin
      alu_in1    = req1_a;
      alu_in2    = req1_b;
      alu_opcode = req1_op;
    end
  end

  assign cap_data     = is_ctrl_op(alu_opcode) ? '0 : alu_out;
  assign alu_flag_wen = grant[0] & is_flag_op(req0_op);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign busy       = (|rsp_valid) | (|req_valid);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int DW      = 16;
  localparam int OPW     = 4;
  localparam int RR_INIT = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic [DW-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0]  rsp0_data, rsp1_data, alu_in1, alu_in2, alu_out;
  logic [OPW-1:0] alu_opcode;
  logic           alu_flag_wen, busy;

  always #5 clk = ~clk;

  // Stand-in ALU; its exact function matters only in that bench and DUT agree.
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sh;
    sh = int'(b[3:0]);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a ^ b;
      4'h3:    return 16'(a[15:8]) + 16'(a[7:0]) + 16'(b[15:8]) + 16'(b[7:0]);
      4'h4:    return a << sh;
      4'h5:    return 16'($signed(a) >>> sh);
      4'h6:    return (a >> sh) | (a << (16 - sh));
      default: return a & b;
    endcase
  endfunction

  function automatic logic flag_op(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
  endfunction

  assign alu_out = alu_f(alu_opcode, alu_in1, alu_in2);

  alu_arbiter #(.DW(DW), .OPW(OPW), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .alu_flag_wen(alu_flag_wen), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-port pending result and the priority port.
  logic          m_v [2] = '{1'b0, 1'b0};
  logic [15:0]   m_d [2] = '{16'h0, 16'h0};
  logic          m_ptr   = (RR_INIT != 0);
  logic          hs  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic        rv [2], rr [2];
    logic [3:0]  op [2];
    logic [15:0] a [2], b [2];
    logic [1:0]  e, g;
    int          w;
    rv = '{req0_valid, req1_valid};
    rr = '{rsp0_ready, rsp1_ready};
    op = '{req0_op, req1_op};
    a  = '{req0_a, req1_a};
    b  = '{req0_b, req1_b};
    for (int p = 0; p < 2; p++) e[p] = rv[p] && (!m_v[p] || rr[p]);
    g = 2'b00;
    if (!rst) begin
      if (e == 2'b11) g[m_ptr] = 1'b1;
      else            g = e;
    end
    w = g[1] ? 1 : 0;

    chk("req0_ready", 32'(req0_ready), 32'(g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(g[1]));
    chk("alu_in1",    32'(alu_in1),    (g != 0) ? 32'(a[w]) : 32'h0);
    chk("alu_in2",    32'(alu_in2),    (g != 0) ? 32'(b[w]) : 32'h0);
    chk("alu_opcode", 32'(alu_opcode), (g != 0) ? 32'(op[w]) : 32'h3);
    chk("alu_flag_wen", 32'(alu_flag_wen), 32'(g[0] && flag_op(op[0])));
    chk("busy", 32'(busy), 32'(m_v[0] || m_v[1] || rv[0] || rv[1]));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_v[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_v[1]));
    if (m_v[0]) chk("rsp0_data", 32'(rsp0_data), 32'(m_d[0]));
    if (m_v[1]) chk("rsp1_data", 32'(rsp1_data), 32'(m_d[1]));
    if (m_v[0] && rr[0]) $display("rsp0 delivered data=%04h at %0t", rsp0_data, $time);
    if (m_v[1] && rr[1]) $display("rsp1 delivered data=%04h at %0t", rsp1_data, $time);

    for (int p = 0; p < 2; p++) hs[p] = rv[p] && g[p];

    if (rst) begin
      m_v   = '{1'b0, 1'b0};
      m_d   = '{16'h0, 16'h0};
      m_ptr = (RR_INIT != 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          m_v[p] = 1'b1;
          m_d[p] = (op[p] >= 4'hC) ? 16'h0 : alu_f(op[p], a[p], b[p]);
        end else if (m_v[p] && rr[p]) begin
          m_v[p] = 1'b0;
        end
      end
      if (g[0])      m_ptr = 1'b1;
      else if (g[1]) m_ptr = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both ports requesting.
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_op = 4'h0; req1_a = 16'h0002; req1_b = 16'h0002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'h0);
      chk("rst_req1_ready", 32'(req1_ready), 32'h0);
      chk("rst_flag_wen", 32'(alu_flag_wen), 32'h0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
      chk("rst_rsp0_data", 32'(rsp0_data), 32'h0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant0", 32'(req0_ready), 32'h1);
    chk("first_grant1", 32'(req1_ready), 32'h0);

    // Single port ADD 3+4.
    step();
    req1_valid = 1'b0;
    req0_op = 4'h0; req0_a = 16'h0003; req0_b = 16'h0004;
    @(negedge clk);
    chk("add_ready", 32'(req0_ready), 32'h1);
    chk("add_flag_wen", 32'(alu_flag_wen), 32'h1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'h1; req1_a = 16'h0005; req1_b = 16'h0005;
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp0_valid), 32'h1);
    chk("add_rsp_data", 32'(rsp0_data), 32'h0007);
    chk("sub_single_ready", 32'(req1_ready), 32'h1);
    chk("sub_single_flag", 32'(alu_flag_wen), 32'h0);

    // Contention: priority now at port 0, grants must go 0,1,0,1.
    step();
    req0_valid = 1'b1; req0_op = 4'h2; req0_a = 16'h00F0; req0_b = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_grant0", 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_grant1", 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
      if (i == 0) chk("sub_rsp1_data", 32'(rsp1_data), 32'h0);
      if (i % 2 == 1) chk("cont_flag1", 32'(alu_flag_wen), 32'h0);
    end

    // Backpressure on port 0.
    step();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_fill_grant0", 32'(req0_ready), 32'h1);
    step();
    req0_op = 4'h0; req0_a = 16'h1234; req0_b = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_block0", 32'(req0_ready), 32'h0);
      chk("bp_grant1", 32'(req1_ready), 32'h1);
      if (i < 2) step();
    end
    step();
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release0", 32'(req0_ready), 32'h1);
    chk("bp_drain_valid", 32'(rsp0_valid), 32'h1);
    step();
    req1_valid = 1'b0;
    req0_op = 4'hF; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
    @(negedge clk);
    chk("bp_refill_valid", 32'(rsp0_valid), 32'h1);
    chk("bp_refill_data", 32'(rsp0_data), 32'h2345);
    chk("hlt_ready", 32'(req0_ready), 32'h1);
    chk("hlt_flag_wen", 32'(alu_flag_wen), 32'h0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("hlt_rsp_valid", 32'(rsp0_valid), 32'h1);
    chk("hlt_rsp_data", 32'(rsp0_data), 32'h0);

    // Reset while port 1 holds an undelivered result.
    step();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'h0; req1_a = 16'h0001; req1_b = 16'h0002;
    @(negedge clk);
    chk("mid_grant1", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("mid_rsp1_full", 32'(rsp1_valid), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rsp1_dropped", 32'(rsp1_valid), 32'h0);
    end

    // Randomised traffic; request fields held until accepted.
    repeat (1000) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (!(req0_valid && !hs[0])) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = 4'($urandom_range(0, 15));
        req0_a  = 16'($urandom);
        req0_b  = 16'($urandom);
      end
      if (!(req1_valid && !hs[1])) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op = 4'($urandom_range(0, 15));
        req1_a  = 16'($urandom);
        req1_b  = 16'($urandom);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit ALU between two requesters: port 0 is the pipeline EX stage, and port 1 is the address-generation/auxiliary unit. The block uses a round-robin grant with valid/ready handshakes on both sides. Each port has a one-entry registered response buffer. The block also gates ALU flag writes so that only pipeline (port 0) flag-setting ops update N/Z/V. It sits between the EX-stage issue logic and the combinational ALU datapath.

Parameters:
DW, 16, operand/result width
OPW, 4, ALU opcode width
RR_INIT, 0, port that holds round-robin priority after reset (0 or 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op  in  OPW  port 0 ALU opcode
req0_a  in  DW  port 0 operand 1
req0_b  in  DW  port 0 operand 2
rsp0_valid  out  1  port 0 result valid
rsp0_ready  in  1  port 0 consumer takes result
rsp0_data  out  DW  port 0 result
req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1
alu_in1  out  DW  to ALU operand 1
alu_in2  out  DW  to ALU operand 2
alu_opcode  out  OPW  to ALU opcode
alu_out  in  DW  ALU combinational result
alu_flag_wen  out  1  permits ALU N/Z/V update this cycle
busy  out  1  any rsp buffer occupied or any req_valid high

Behaviour:
- Reset (rst=1 at an edge) sets rsp0_valid=0, rsp1_valid=0, rsp data=0, and priority pointer=RR_INIT.
  - While rst=1, both req_ready=0 and alu_flag_wen=0.
  - Reset mid-operation discards buffered results; they are not delivered.
- Eligibility: port N is eligible when reqN_valid=1 and its rsp buffer is empty or being drained this cycle (rspN_valid & rspN_ready).
- Grant (combinational, same cycle):
  - If only one port is eligible, that port is granted.
  - If both are eligible, the pointer port is granted.
  - At most one grant per cycle.
  - reqN_ready = grantN. A handshake occurs when valid & ready.
- Pointer update: after any grant, the pointer moves to the non-granted port. With no grant, the pointer is held.
- Datapath muxing:
  - alu_in1/alu_in2/alu_opcode come from the granted port.
  - With no grant they are driven to 0/0/4'b0011 (RED, no flag effect).
- Latency: request accepted in cycle T; alu_out is captured into the rsp buffer at the end of T; rspN_valid=1 from T+1 until rspN_ready.
- Response buffer:
  - One entry per port; held stable while rspN_valid & !rspN_ready.
  - Simultaneous drain and refill in the same cycle is allowed, giving back-to-back throughput of 1 result/cycle per port.
- Opcodes 4'b1100–4'b1111 (B/BR/PCS/HLT): accepted, result buffered as 16'h0000, alu_flag_wen=0.
- alu_flag_wen=1 only when grant0=1 and req0_op is in {ADD 0000, SUB 0001, XOR 0010, SLL 0100, SRA 0101, ROR 0110}. It is never asserted for port 1.
- Fairness: with both ports continuously eligible, grants alternate strictly, so each port is granted within 2 cycles.
- Requester obligation: req fields must be held stable while valid & !ready. The arbiter does not check this.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (ADD..HLT)
  - function is_flag_op(op) returning the flag-writing mask above
  - function is_ctrl_op(op) for the 11xx group
- Sub-module: alu_rsp_buf, a one-entry valid/ready register slice with drain-and-refill. It is instantiated twice, and the arbiter core holds the pointer and grant logic.

Test Plan:
- Reset: after rst held 2 cycles with both req_valid=1 → req_ready=0 during reset, rsp_valid=0, and the first grant after reset goes to RR_INIT port.
- Single port: req0 ADD a=16'h0003 b=16'h0004 accepted at T → rsp0_valid at T+1, rsp0_data=16'h0007, alu_flag_wen=1 at T.
- Contention: both ports valid for 4 cycles, rsp_ready=1 → grants 0,1,0,1 (RR_INIT=0); port 1 SUB 16'h0005-16'h0005 gives rsp1_data=0 with alu_flag_wen=0.
- Backpressure: rsp0_ready=0 with rsp0 full and req0_valid=1 → req0_ready=0; port 1 is granted every cycle; when rsp0_ready rises, port 0 is granted the same cycle and rsp0 drains/refills with no bubble.
- Control op: req0_op=4'b1111 → accepted, rsp0_data=16'h0000, alu_flag_wen=0.
- Mid-operation reset: rst asserted with rsp1_valid=1 → next cycle rsp1_valid=0, and the old data is never delivered after rst deasserts.
